// File: rtl/clk_div_prog.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// clk_div_prog
// Programmable integer clock divider with a 50% duty cycle for every ratio N.
// An even N uses only the posedge phase term. An odd N ORs in a copy of that
// term delayed by half a Clk period. N=1 gates Clk itself.
// A new ratio is held as pending and takes effect only on a period boundary.
// When the divider is idle, a new ratio takes effect at once.
//
// Ports
//   Clk        : input clock (rising edge, except the negedge flops)
//   rst_n      : asynchronous active-low reset
//   en         : run request (level)
//   load       : one-cycle strobe, captures div_ratio
//   div_ratio  : requested divide ratio N (0 is rejected)
//   clk_div    : divided clock
//   clk_pose   : posedge-phase term, high while cout_pose < N/2
//   clk_nege   : clk_pose delayed half a cycle (odd N only)
//   cout_pose  : period counter 0..N-1
//   cout_nege  : cout_pose recaptured on the falling edge
//   ratio_cur  : ratio currently in force
//   tick       : high during the cycle with cout_pose == 0 while active
//   busy       : high when not IDLE
//   err        : one-cycle pulse after a rejected load
// -----------------------------------------------------------------------------
module clk_div_prog #(
    parameter int WIDTH     = 8,
    parameter int DEF_RATIO = 5
) (
    input  logic             Clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div_ratio,
    output logic             clk_div,
    output logic             clk_pose,
    output logic             clk_nege,
    output logic [WIDTH-1:0] cout_pose,
    output logic [WIDTH-1:0] cout_nege,
    output logic [WIDTH-1:0] ratio_cur,
    output logic             tick,
    output logic             busy,
    output logic             err
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_cout_pose;
    logic [WIDTH-1:0] r_cout_nege;
    logic [WIDTH-1:0] r_ratio_cur;
    logic [WIDTH-1:0] r_pend_ratio;
    logic             r_pend_vld;
    logic             r_clk_pose;
    logic             r_clk_nege;
    logic             r_byp_en;
    logic             r_tick;
    logic             r_busy;
    logic             r_err;

    state_t           w_state_nx;
    logic [WIDTH-1:0] w_cout_nx;
    logic [WIDTH-1:0] w_ratio_nx;
    logic             w_active;
    logic             w_wrap;
    logic             w_load_ok;
    logic             w_apply;
    logic             w_active_nx;

    assign w_active  = (r_state != S_IDLE);
    // The last count of a period: the next rising edge starts a new period.
    assign w_wrap    = w_active && (r_cout_pose == (r_ratio_cur - WIDTH'(1)));
    assign w_load_ok = load && (div_ratio != '0);
    // A new ratio may only take effect on a period boundary or while idle.
    assign w_apply   = w_wrap || !w_active;

    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE:  if (en) w_state_nx = S_RUN;
            S_RUN:   if (!en) w_state_nx = S_DRAIN;
            S_DRAIN: begin
                if (en)          w_state_nx = S_RUN;
                else if (w_wrap) w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase

        // A load on the boundary edge wins over an older pending value.
        w_ratio_nx = r_ratio_cur;
        if (w_apply) begin
            if (w_load_ok)       w_ratio_nx = div_ratio;
            else if (r_pend_vld) w_ratio_nx = r_pend_ratio;
        end

        w_active_nx = (w_state_nx != S_IDLE);
        if (!w_active_nx || !w_active || w_wrap) w_cout_nx = '0;
        else                                     w_cout_nx = r_cout_pose + WIDTH'(1);
    end

    // The phase term, tick and busy come from the next-state values.
    // This keeps them registered and aligned with the counter they describe.
    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cout_pose  <= '0;
            r_ratio_cur  <= WIDTH'(DEF_RATIO);
            r_pend_ratio <= '0;
            r_pend_vld   <= 1'b0;
            r_clk_pose   <= 1'b0;
            r_tick       <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cout_pose <= w_cout_nx;
            r_ratio_cur <= w_ratio_nx;
            r_clk_pose  <= w_active_nx && (w_cout_nx < (w_ratio_nx >> 1));
            r_tick      <= w_active_nx && (w_cout_nx == '0);
            r_busy      <= w_active_nx;
            r_err       <= load && (div_ratio == '0);

            if (w_apply) begin
                r_pend_vld <= 1'b0;
            end else if (w_load_ok) begin
                r_pend_vld   <= 1'b1;
                r_pend_ratio <= div_ratio;
            end
        end
    end

    // Falling-edge flops: the half-cycle extension for odd N, and the N=1 gate enable.
    // The enable changes only while Clk is low, so Clk & r_byp_en cannot produce a runt pulse.
    always_ff @(negedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_nege  <= 1'b0;
            r_cout_nege <= '0;
            r_byp_en    <= 1'b0;
        end else begin
            r_clk_nege  <= r_clk_pose & r_ratio_cur[0];
            r_cout_nege <= r_cout_pose;
            r_byp_en    <= w_active && (r_ratio_cur == WIDTH'(1));
        end
    end

    // r_clk_nege is always 0 for even N, so one OR serves both parities.
    // r_clk_pose stays 0 for N=1, leaving only the gated-clock term.
    assign clk_div   = r_clk_pose | r_clk_nege | (Clk & r_byp_en);
    assign clk_pose  = r_clk_pose;
    assign clk_nege  = r_clk_nege;
    assign cout_pose = r_cout_pose;
    assign cout_nege = r_cout_nege;
    assign ratio_cur = r_ratio_cur;
    assign tick      = r_tick;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule

// File: tb/tb_clk_div_prog.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_clk_div_prog
// Directed bench for clk_div_prog (WIDTH=8, DEF_RATIO=5, Clk period 20 ns).
// Inputs change just after a falling edge. Outputs are sampled 1 ns after a
// Clk edge. Waveform widths are measured in 10 ns half-cycle samples.
// -----------------------------------------------------------------------------
module tb_clk_div_prog;

    localparam int WIDTH = 8;

    logic             Clk;
    logic             rst_n;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] div_ratio;
    logic             clk_div;
    logic             clk_pose;
    logic             clk_nege;
    logic [WIDTH-1:0] cout_pose;
    logic [WIDTH-1:0] cout_nege;
    logic [WIDTH-1:0] ratio_cur;
    logic             tick;
    logic             busy;
    logic             err;

    int n_checks = 0;
    int n_fail   = 0;

    clk_div_prog #(.WIDTH(WIDTH), .DEF_RATIO(5)) u_dut (
        .Clk       (Clk),
        .rst_n     (rst_n),
        .en        (en),
        .load      (load),
        .div_ratio (div_ratio),
        .clk_div   (clk_div),
        .clk_pose  (clk_pose),
        .clk_nege  (clk_nege),
        .cout_pose (cout_pose),
        .cout_nege (cout_nege),
        .ratio_cur (ratio_cur),
        .tick      (tick),
        .busy      (busy),
        .err       (err)
    );

    // Rising edges fall at 20, 40, ...; the reset release at 30 ns lands on a falling edge.
    initial begin
        Clk = 1'b1;
        forever #10 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to 1 ns after the next falling edge.
    task automatic step();
        @(negedge Clk);
        #1;
    endtask

    task automatic wait_cout(input int v);
        bit found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            step();
            if (cout_pose == 8'(v)) found = 1'b1;
        end
        check("wait_cout_timeout", found, 1);
    endtask

    task automatic wait_ratio(input int v);
        bit found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            step();
            if (ratio_cur == 8'(v)) found = 1'b1;
        end
        check("wait_ratio_timeout", found, 1);
    endtask

    // Find a rising edge of clk_div, then time one full high and low phase.
    task automatic measure(input string tag, input int exp_per_ns, input int exp_hi_ns);
        int  hi = 0;
        int  lo = 0;
        int  n  = 0;
        bit  ok = 1'b1;
        while (ok && clk_div !== 1'b0) begin @(Clk); #1; n++; if (n > 400) ok = 1'b0; end
        while (ok && clk_div !== 1'b1) begin @(Clk); #1; n++; if (n > 400) ok = 1'b0; end
        while (ok && clk_div === 1'b1) begin @(Clk); #1; hi++; if (hi > 400) ok = 1'b0; end
        while (ok && clk_div === 1'b0) begin @(Clk); #1; lo++; if (lo > 400) ok = 1'b0; end
        check({tag, "_timeout"}, ok, 1);
        check({tag, "_period_ns"}, (hi + lo) * 10, exp_per_ns);
        check({tag, "_high_ns"}, hi * 10, exp_hi_ns);
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        load      = 1'b0;
        div_ratio = '0;

        // Reset state.
        #5;
        check("rst_clk_div", clk_div, 0);
        check("rst_busy", busy, 0);
        check("rst_tick", tick, 0);
        check("rst_cout_pose", cout_pose, 0);
        check("rst_ratio_cur", ratio_cur, 5);

        // Default N=5: counter sequence, tick, phase terms.
        #25 rst_n = 1'b1;
        @(posedge Clk);
        for (int i = 0; i < 10; i++) begin
            step();
            check("n5_cout_pose", cout_pose, i % 5);
            check("n5_cout_nege", cout_nege, i % 5);
            check("n5_tick", tick, (i % 5) == 0);
            check("n5_clk_pose", clk_pose, (i % 5) < 2);
            check("n5_busy", busy, 1);
        end
        measure("n5", 100, 50);

        // Load 4 mid-period: the current period finishes, then N=4 applies.
        wait_cout(2);
        load = 1'b1; div_ratio = 8'd4;
        step(); load = 1'b0;
        check("ld4_cout3", cout_pose, 3);
        check("ld4_ratio_hold", ratio_cur, 5);
        step();
        check("ld4_cout4", cout_pose, 4);
        check("ld4_ratio_hold2", ratio_cur, 5);
        step();
        check("ld4_cout_wrap", cout_pose, 0);
        check("ld4_ratio_new", ratio_cur, 4);
        measure("n4", 80, 40);

        // A rejected load of 0 gives a one-cycle err and no ratio change.
        step();
        load = 1'b1; div_ratio = 8'd0;
        step(); load = 1'b0;
        check("ld0_err_pulse", err, 1);
        check("ld0_ratio", ratio_cur, 4);
        step();
        check("ld0_err_clear", err, 0);
        measure("n4_after_ld0", 80, 40);

        // N=1 bypass: clk_div follows Clk.
        step();
        load = 1'b1; div_ratio = 8'd1;
        step(); load = 1'b0;
        wait_ratio(1);
        for (int i = 0; i < 8; i++) begin
            @(Clk); #1;
            check("n1_follow_clk", clk_div, Clk);
        end
        step();
        check("n1_tick", tick, 1);
        check("n1_cout", cout_pose, 0);
        measure("n1", 20, 10);

        // Reload to 3 from N=1; every edge is a boundary, so it applies at once.
        step();
        load = 1'b1; div_ratio = 8'd3;
        step(); load = 1'b0;
        check("ld3_ratio", ratio_cur, 3);
        measure("n3", 60, 30);

        // Two loads before the boundary: the last one wins.
        wait_cout(0);
        load = 1'b1; div_ratio = 8'd7;
        step();
        div_ratio = 8'd6;
        step(); load = 1'b0;
        check("lastwin_hold", ratio_cur, 3);
        step();
        check("lastwin_ratio", ratio_cur, 6);

        // N=6 drain: en drops at cout 2, the period completes, then IDLE.
        wait_cout(2);
        en = 1'b0;
        for (int c = 3; c <= 5; c++) begin
            step();
            check("drain_cout", cout_pose, c);
            check("drain_busy", busy, 1);
            check("drain_clk_div_low", clk_div, 0);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            check("idle_busy", busy, 0);
            check("idle_cout", cout_pose, 0);
            check("idle_clk_div", clk_div, 0);
            check("idle_cout_nege", cout_nege, 0);
        end

        // Re-enable, then raise en again while draining: the output must not break.
        en = 1'b1;
        wait_cout(2);
        en = 1'b0;
        step();
        check("redrain_cout3", cout_pose, 3);
        step();
        en = 1'b1;
        step();
        check("resume_cout5", cout_pose, 5);
        check("resume_busy", busy, 1);
        step();
        check("resume_cout0", cout_pose, 0);
        check("resume_tick", tick, 1);
        check("resume_clk_pose", clk_pose, 1);
        measure("n6", 120, 60);

        // Reset mid-period with a pending ratio; the pending value must be dropped.
        wait_cout(2);
        load = 1'b1; div_ratio = 8'd7;
        step(); load = 1'b0;
        check("prerst_cout3", cout_pose, 3);
        #3 rst_n = 1'b0;
        #2;
        check("arst_cout_pose", cout_pose, 0);
        check("arst_cout_nege", cout_nege, 0);
        check("arst_busy", busy, 0);
        check("arst_clk_div", clk_div, 0);
        check("arst_clk_pose", clk_pose, 0);
        check("arst_clk_nege", clk_nege, 0);
        check("arst_tick", tick, 0);
        check("arst_ratio", ratio_cur, 5);
        @(negedge Clk);
        #5 rst_n = 1'b1;
        measure("post_rst", 100, 50);

        // A load on the wrap edge applies at that same boundary.
        wait_cout(4);
        load = 1'b1; div_ratio = 8'd3;
        step(); load = 1'b0;
        check("coinc_ratio", ratio_cur, 3);
        check("coinc_cout", cout_pose, 0);
        measure("coinc_n3", 60, 30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameter WIDTH, 8, width of divide ratio and counters; legal 2..16.
REQ-002 Parameter DEF_RATIO, 5, divide ratio loaded at reset; legal 1..2^WIDTH-1.
REQ-003 Clk  input  1  single clock; all flops on its rising edge except those named "negedge".
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  run request, level.
REQ-006 load  input  1  one-cycle strobe; captures div_ratio.
REQ-007 div_ratio  input  WIDTH  requested divide ratio N.
REQ-008 clk_div  output  1  divided clock, 50% duty for every N.
REQ-009 clk_pose  output  1  posedge-phase term.
REQ-010 clk_nege  output  1  negedge-phase term.
REQ-011 cout_pose  output  WIDTH  posedge period counter.
REQ-012 cout_nege  output  WIDTH  cout_pose recaptured on negedge.
REQ-013 ratio_cur  output  WIDTH  ratio in force.
REQ-014 tick  output  1  high during Clk cycles with cout_pose==0 in RUN/DRAIN.
REQ-015 busy  output  1  high when state is not IDLE.
REQ-016 err  output  1  one-cycle pulse on rejected load.

Function
REQ-017 FSM states IDLE, RUN, DRAIN; IDLE->RUN on posedge with en=1; RUN->DRAIN on en=0; DRAIN->RUN on en=1 (no break in output); DRAIN->IDLE at the posedge where cout_pose wraps.
REQ-018 Entering RUN: cout_pose<=0, clk_pose<=1 (N>=2); thereafter cout_pose increments 0..N-1 and wraps to 0.
REQ-019 H = ratio_cur>>1; clk_pose registered, equal to (cout_pose < H) in RUN/DRAIN, 0 in IDLE.
REQ-020 clk_nege: negedge flop capturing clk_pose when ratio_cur[0]=1, else 0.
REQ-021 clk_div = clk_pose|clk_nege for odd N, clk_pose for even N; high time exactly N/2 Clk periods.
REQ-022 N=1 bypass: enable flop sampled on Clk negedge = (state!=IDLE and ratio_cur==1); clk_div = Clk AND that flop; glitch-free.
REQ-023 load with div_ratio>=1: value stored as pending; later load before application overwrites (last wins).
REQ-024 Pending ratio applied at next period boundary (wrap posedge) or immediately when IDLE; never mid-period.
REQ-025 load coincident with wrap posedge: new div_ratio applied at that same boundary.
REQ-026 load with div_ratio=0: ignored, pending unchanged, err=1 next cycle only.
REQ-027 cout_nege follows cout_pose one half-cycle late; both held at 0 in IDLE.

Reset
REQ-028 rst_n=0 forces immediately: state IDLE, all counters 0, clk_pose/clk_nege/clk_div/tick/busy/err 0, ratio_cur=DEF_RATIO, pending cleared.
REQ-029 Reset mid-period aborts period; first period after release is full length.
REQ-030 Negedge flops use same asynchronous reset.

Verification
REQ-031 Clk 20 ns, DEF_RATIO=5, release rst_n at 30 ns, en=1 -> clk_div period 100 ns, high 50 ns; cout_pose 0,1,2,3,4 repeating; tick every 100 ns.
REQ-032 N=5 running, load div_ratio=4 at cout_pose=2 -> current 100 ns period completes; then 80 ns periods, high 40 ns; ratio_cur=4 from the boundary.
REQ-033 load div_ratio=0 -> err one cycle, ratio_cur and clk_div unchanged.
REQ-034 load div_ratio=1 -> after boundary clk_div identical to Clk, no runt pulse; reload 3 -> 60 ns period, high 30 ns.
REQ-035 N=6, en=0 at cout_pose=2 -> counts to 5, clk_div stays low, busy=0 after wrap; en=1 in DRAIN at cout_pose=4 -> no gap.
REQ-036 rst_n=0 at cout_pose=3 -> all outputs 0 asynchronously, ratio_cur=5; after release full 100 ns period.
